// File: rtl/pinv_matvec_engine_if.sv
// Handshake and operand bus for the pseudoinverse matrix-vector engine.
// The master drives the operands and start; the slave (the engine) returns y and status.
interface pinv_matvec_engine_if #(
  parameter int M     = 4,
  parameter int N     = M - 1,
  parameter int nBits = 32
);
  logic                   i_start;
  logic                   i_mode;
  logic [nBits-1:0]       i_dim;
  logic [M*N*nBits-1:0]   i_p;
  logic [M*nBits-1:0]     i_x;
  logic [M*nBits-1:0]     o_y;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_sat;

  modport master (
    output i_start, i_mode, i_dim, i_p, i_x,
    input  o_y, o_busy, o_done, o_sat
  );

  modport slave (
    input  i_start, i_mode, i_dim, i_p, i_x,
    output o_y, o_busy, o_done, o_sat
  );
endinterface

// File: rtl/pinv_matvec_engine.sv
// Sequential y = P*x / y = P^T*x on a packed N x M pseudoinverse using a single shared MAC.
// state  | meaning
// IDLE   | waiting for start; y and sat hold the previous result
// MAC    | one product per cycle into the accumulator for output slot k
// NORM   | round, clamp and write slot k; advance to the next slot or finish
// DONE   | one-cycle done pulse, busy still high
module pinv_matvec_engine #(
  parameter int M     = 4,
  parameter int N     = M - 1,
  parameter int nBits = 32,
  parameter int FRAC  = 15,
  parameter int GUARD = 8
) (
  input logic                clk,
  input logic                rst_n,
  pinv_matvec_engine_if.slave bus
);

  localparam int AW   = 2*nBits + GUARD;
  localparam int MAXD = (M > N) ? M : N;
  localparam int CW   = $clog2(MAXD + 1);
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_NORM, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_mode;
  logic [CW-1:0]            r_dim_eff;
  logic [CW-1:0]            r_k;
  logic [CW-1:0]            r_j;
  logic signed [AW-1:0]     r_acc;
  logic signed [nBits-1:0]  r_p [N][M];
  logic signed [nBits-1:0]  r_x [M];
  logic [nBits-1:0]         r_y [M];
  logic                     r_busy;
  logic                     r_done;
  logic                     r_sat;

  logic [CW-1:0]            w_l_last;
  logic [CW-1:0]            w_k_last;
  logic [CW-1:0]            w_row;
  logic [CW-1:0]            w_col;
  logic signed [nBits-1:0]  w_a;
  logic signed [nBits-1:0]  w_b;
  logic                     w_mask;
  logic signed [2*nBits-1:0] w_prod;
  logic signed [AW-1:0]     w_term;
  logic signed [AW-1:0]     w_rnd;
  logic signed [AW-1:0]     w_shr;
  logic                     w_ovf;
  logic [nBits-1:0]         w_res;
  logic [M*nBits-1:0]       w_y;

  // Mode 1 walks P transposed: the inner index selects the row.
  assign w_l_last = r_mode ? CW'(N - 1) : CW'(M - 1);
  assign w_k_last = r_mode ? CW'(M - 1) : CW'(N - 1);
  assign w_row    = r_mode ? r_j : r_k;
  assign w_col    = r_mode ? r_k : r_j;
  assign w_mask   = r_mode ? (r_j > r_dim_eff) : (r_k > r_dim_eff);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < M; c++)
        if (w_row == CW'(i) && w_col == CW'(c)) w_a = r_p[i][c];
    for (int c = 0; c < M; c++)
      if (r_j == CW'(c)) w_b = r_x[c];
  end

  assign w_prod = w_a * w_b;
  assign w_term = w_mask ? '0 : {{GUARD{w_prod[2*nBits-1]}}, w_prod};

  // Round half up, then detect any significant bits above the output word.
  assign w_rnd = r_acc + HALF;
  assign w_shr = w_rnd >>> FRAC;
  assign w_ovf = ~((&w_shr[AW-1:nBits-1]) | ~(|w_shr[AW-1:nBits-1]));
  assign w_res = w_ovf ? (w_shr[AW-1] ? {1'b1, {(nBits-1){1'b0}}} : {1'b0, {(nBits-1){1'b1}}})
                       : w_shr[nBits-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.i_start) w_next = S_MAC;
      S_MAC:   if (r_j == w_l_last) w_next = S_NORM;
      S_NORM:  w_next = (r_k == w_k_last) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_dim_eff <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int c = 0; c < M; c++) r_p[i][c] <= '0;
      for (int c = 0; c < M; c++) begin
        r_x[c] <= '0;
        r_y[c] <= '0;
      end
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: if (bus.i_start) begin
          r_mode    <= bus.i_mode;
          r_dim_eff <= (bus.i_dim >= nBits'(N - 1)) ? CW'(N - 1) : bus.i_dim[CW-1:0];
          r_k       <= '0;
          r_j       <= '0;
          r_acc     <= '0;
          r_sat     <= 1'b0;
          for (int i = 0; i < N; i++)
            for (int c = 0; c < M; c++)
              r_p[i][c] <= bus.i_p[M*N*nBits - M*i*nBits - c*nBits - 1 -: nBits];
          for (int c = 0; c < M; c++) begin
            r_x[c] <= bus.i_x[M*nBits - c*nBits - 1 -: nBits];
            r_y[c] <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_term;
          if (r_j != w_l_last) r_j <= r_j + CW'(1);
        end
        S_NORM: begin
          for (int c = 0; c < M; c++)
            if (r_k == CW'(c)) r_y[c] <= w_res;
          if (w_ovf) r_sat <= 1'b1;
          r_acc <= '0;
          r_j   <= '0;
          if (r_k != w_k_last) r_k <= r_k + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_y = '0;
    for (int c = 0; c < M; c++) w_y[M*nBits - c*nBits - 1 -: nBits] = r_y[c];
  end

  assign bus.o_y    = w_y;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_sat  = r_sat;

endmodule

// File: tb/tb_pinv_matvec_engine.sv
// Bench for pinv_matvec_engine: directed vector table, randomized operations against an
// arithmetic reference model, and start-while-busy / mid-operation reset sequences.
module tb_pinv_matvec_engine;
  localparam int M  = 4;
  localparam int N  = 3;
  localparam int NB = 32;
  localparam int PW = M*N*NB;
  localparam int XW = M*NB;

  typedef struct {
    string          name;
    logic           mode;
    logic [31:0]    dim;
    logic [PW-1:0]  p;
    logic [XW-1:0]  x;
    logic [XW-1:0]  y;
    logic           sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pinv_matvec_engine_if #(.M(M), .N(N), .nBits(NB)) b();

  pinv_matvec_engine #(.M(M), .N(N), .nBits(NB), .FRAC(15), .GUARD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] p_set(input logic [PW-1:0] p, input int i, input int j,
                                          input logic [31:0] v);
    p[PW - M*i*NB - j*NB - 1 -: NB] = v;
    return p;
  endfunction

  function automatic logic signed [31:0] p_get(input logic [PW-1:0] p, input int i, input int j);
    return p[PW - M*i*NB - j*NB - 1 -: NB];
  endfunction

  function automatic logic signed [31:0] x_get(input logic [XW-1:0] x, input int j);
    return x[XW - j*NB - 1 -: NB];
  endfunction

  // Reference: plain sums of products with wide arithmetic, then round and clamp.
  task automatic model(input logic m, input logic [31:0] d, input logic [PW-1:0] p,
                       input logic [XW-1:0] xv, output logic [XW-1:0] yo, output logic so);
    int de, nout, nin;
    logic signed [79:0] acc, r;
    logic signed [31:0] pe, xe;
    de   = (d >= 32'd2) ? 2 : int'(d);
    nout = m ? M : N;
    nin  = m ? N : M;
    yo = '0;
    so = 1'b0;
    for (int o = 0; o < nout; o++) begin
      acc = '0;
      for (int t = 0; t < nin; t++) begin
        pe = m ? p_get(p, t, o) : p_get(p, o, t);
        xe = x_get(xv, t);
        if ((!m && o <= de) || (m && t <= de)) acc = acc + pe * xe;
      end
      r = (acc + 80'sd16384) >>> 15;
      if (r > 80'sd2147483647) begin
        r = 80'sd2147483647; so = 1'b1;
      end else if (r < -80'sd2147483648) begin
        r = -80'sd2147483648; so = 1'b1;
      end
      yo[XW - o*NB - 1 -: NB] = r[31:0];
    end
  endtask

  task automatic run_op(input string nm, input logic m, input logic [31:0] d,
                        input logic [PW-1:0] p, input logic [XW-1:0] xv,
                        input logic [XW-1:0] ey, input logic es);
    int lat;
    @(negedge clk);
    b.i_mode = m; b.i_dim = d; b.i_p = p; b.i_x = xv; b.i_start = 1'b1;
    @(posedge clk); #1;
    b.i_start = 1'b0;
    // Scramble operands to confirm they were latched at accept.
    b.i_mode = ~m; b.i_dim = $urandom; b.i_p = {12{$urandom}}; b.i_x = ~xv;
    chk({nm, " busy_at_accept"}, b.o_busy, 1);
    chk({nm, " y_cleared"}, b.o_y, 0);
    chk({nm, " sat_cleared"}, b.o_sat, 0);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (b.o_done) begin lat = n; break; end
    end
    chk({nm, " done_edge"}, lat, m ? 16 : 15);
    chk({nm, " y"}, b.o_y, ey);
    chk({nm, " sat"}, b.o_sat, es);
    chk({nm, " busy_in_done"}, b.o_busy, 1);
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, b.o_done, 0);
    chk({nm, " busy_fall"}, b.o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t          tv[10];
    logic [PW-1:0] pd, p1, pr;
    logic [XW-1:0] xr, ey;
    logic [31:0]   e, dr;
    logic          es, mr;
    int            ndone, first;

    b.i_start = 1'b0; b.i_mode = 1'b0; b.i_dim = '0; b.i_p = '0; b.i_x = '0;

    pd = '0;
    pd = p_set(pd, 0, 0, 32'h00008000);
    pd = p_set(pd, 1, 1, 32'h00008000);
    pd = p_set(pd, 2, 2, 32'h00008000);
    tv[0] = '{"diag_m0", 1'b0, 32'd2, pd,
              {32'h00008000, 32'h00010000, 32'h00018000, 32'h00020000},
              {32'h00008000, 32'h00010000, 32'h00018000, 32'h0}, 1'b0};
    tv[1] = '{"diag_m1", 1'b1, 32'd2, pd,
              {32'h00004000, 32'hFFFF8000, 32'h00010000, 32'hDEADBEEF},
              {32'h00004000, 32'hFFFF8000, 32'h00010000, 32'h0}, 1'b0};
    tv[2] = '{"mask_m0", 1'b0, 32'd0, {12{32'h00008000}}, {4{32'h00008000}},
              {32'h00020000, 32'h0, 32'h0, 32'h0}, 1'b0};
    tv[3] = '{"mask_m1", 1'b1, 32'd0, {12{32'h00008000}}, {4{32'h00008000}},
              {4{32'h00008000}}, 1'b0};
    p1 = p_set('0, 0, 0, 32'h00000001);
    tv[4] = '{"round_up", 1'b0, 32'hFFFFFFFF, p1,
              {32'h00004000, {3{32'h12345678}}}, {32'h1, 96'h0}, 1'b0};
    tv[5] = '{"round_down", 1'b0, 32'hFFFFFFFF, p1,
              {32'h00003FFF, {3{32'h12345678}}}, '0, 1'b0};
    tv[6] = '{"round_neg", 1'b0, 32'hFFFFFFFF, p_set('0, 0, 0, 32'hFFFFFFFF),
              {32'h00004000, {3{32'h12345678}}}, '0, 1'b0};
    tv[7] = '{"sat_pos", 1'b0, 32'd2, p_set('0, 0, 0, 32'h40000000),
              {32'h40000000, 96'h0}, {32'h7FFFFFFF, 96'h0}, 1'b1};
    tv[8] = '{"sat_neg", 1'b0, 32'd2, p_set('0, 0, 0, 32'h40000000),
              {32'hC0000000, 96'h0}, {32'h80000000, 96'h0}, 1'b1};
    tv[9] = tv[0];
    tv[9].name = "sat_clears";

    #12;
    chk("reset_y", b.o_y, 0);
    chk("reset_busy", b.o_busy, 0);
    chk("reset_done", b.o_done, 0);
    chk("reset_sat", b.o_sat, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(tv[i].name, tv[i].mode, tv[i].dim, tv[i].p, tv[i].x, tv[i].y, tv[i].sat);

    for (int r = 0; r < 24; r++) begin
      pr = '0; xr = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < M; j++) begin
          e = $urandom;
          if ($urandom_range(0, 3) != 0) e = {{16{e[15]}}, e[15:0]};
          pr = p_set(pr, i, j, e);
        end
      for (int j = 0; j < M; j++) begin
        e = $urandom;
        if ($urandom_range(0, 3) != 0) e = {{16{e[15]}}, e[15:0]};
        xr[XW - j*NB - 1 -: NB] = e;
      end
      case ($urandom_range(0, 5))
        0: dr = 32'd0;
        1: dr = 32'd1;
        2: dr = 32'd2;
        3: dr = 32'd3;
        4: dr = 32'hFFFFFFFF;
        default: dr = $urandom;
      endcase
      mr = 1'($urandom_range(0, 1));
      model(mr, dr, pr, xr, ey, es);
      run_op($sformatf("rand%0d", r), mr, dr, pr, xr, ey, es);
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    b.i_mode = tv[0].mode; b.i_dim = tv[0].dim; b.i_p = tv[0].p; b.i_x = tv[0].x;
    b.i_start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first = -1;
    for (int ed = 1; ed <= 40; ed++) begin
      @(negedge clk); b.i_start = (ed == 4);
      @(posedge clk); #1;
      if (b.o_done) begin
        ndone++;
        if (first < 0) first = ed;
      end
    end
    b.i_start = 1'b0;
    chk("busy_start_done_count", ndone, 1);
    chk("busy_start_done_edge", first, 15);
    chk("busy_start_y", b.o_y, tv[0].y);

    // reset mid-operation (saturating op so y and sat are nonzero before the abort)
    @(negedge clk);
    b.i_mode = tv[7].mode; b.i_dim = tv[7].dim; b.i_p = tv[7].p; b.i_x = tv[7].x;
    b.i_start = 1'b1;
    @(posedge clk); #1;
    b.i_start = 1'b0;
    for (int ed = 1; ed <= 8; ed++) @(posedge clk);
    #1;
    chk("pre_reset_sat", b.o_sat, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_y", b.o_y, 0);
    chk("abort_busy", b.o_busy, 0);
    chk("abort_done", b.o_done, 0);
    chk("abort_sat", b.o_sat, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int ed = 0; ed < 25; ed++) begin
      @(posedge clk); #1;
      if (b.o_done || b.o_busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("after_reset", tv[0].mode, tv[0].dim, tv[0].p, tv[0].x, tv[0].y, tv[0].sat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
